// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Results are computed from latched operands and become visible only at commit.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic        rd_sel,
  output logic        busy,
  output logic [31:0] out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Result datapath, fed only by the latched operands.
  logic        is_signed;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe;
  logic [31:0] q_mag, r_mag;
  logic [63:0] prod;
  logic [31:0] res_hi, res_lo;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    is_signed = ~op_q[0];
    a_neg     = is_signed & a_q[31];
    b_neg     = is_signed & b_q[31];
    a_mag     = a_neg ? (~a_q + 32'd1) : a_q;
    b_mag     = b_neg ? (~b_q + 32'd1) : b_q;
    // A zero divisor never commits; substituting 1 keeps the divider free of X.
    b_safe    = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag     = a_mag / b_safe;
    r_mag     = a_mag % b_safe;
    if (is_signed)
      prod = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    else
      prod = {32'd0, a_q} * {32'd0, b_q};
    if (op_q[1]) begin
      // Magnitude divide then sign-fix: 0x80000000 / -1 falls out as 0x80000000 rem 0.
      res_lo = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
      res_hi = a_neg ? (~r_mag + 32'd1) : r_mag;
    end else begin
      res_lo = prod[31:0];
      res_hi = prod[63:32];
    end
  end

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    a_d    = a_q;
    b_d    = b_q;
    op_d   = op_q;
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (!busy_q) begin
      // A launch takes priority over mthi/mtlo issued in the same cycle.
      if (start) begin
        a_d    = A;
        b_d    = B;
        op_d   = md_op;
        busy_d = 1'b1;
        cnt_d  = md_op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else begin
        if (hi_we) hi_d = A;
        if (lo_we) lo_d = A;
      end
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        if (!(op_q[1] && (b_q == 32'd0))) begin
          hi_d = res_hi;
          lo_d = res_lo;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      a_q    <= a_d;
      b_q    <= b_d;
      op_q   <= op_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy = busy_q;
  assign out  = rd_sel ? hi_q : lo_q;

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core.
- Sits in EX, in parallel with the ALU.
- Its HI/LO read port drives one data input of the downstream 4:1 32-bit result-select mux, which picks the value written back to the register file.
- Exports busy/start so the hazard unit can stall MD-dependent instructions.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for mult/multu (must be ≥1).
- DIV_CYCLES, 10, busy duration in cycles for div/divu (must be ≥1).

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  launch operation selected by md_op; sampled only when busy=0.
- md_op  input  2  00 mult, 01 multu, 10 div, 11 divu.
- A  input  32  operand rs (multiplicand / dividend).
- B  input  32  operand rt (multiplier / divisor).
- hi_we  input  1  mthi: HI <= A.
- lo_we  input  1  mtlo: LO <= A.
- rd_sel  input  1  0 selects LO, 1 selects HI on out.
- busy  output  1  operation in flight.
- out  output  32  rd_sel ? HI : LO (combinational from committed registers).

Behaviour:
- Reset (synchronous, active-high): HI=0, LO=0, busy=0, cycle counter=0, operand/result temporaries=0. Therefore out=0 after reset.
- Reset asserted mid-operation:
  - The operation is aborted and nothing is committed.
  - busy=0 from the next cycle.
- Launch: at the edge where start=1 and busy=0:
  - A, B and md_op are latched.
  - The counter is loaded with MULT_CYCLES or DIV_CYCLES.
  - busy=1 from the next cycle.
- start while busy=1 is ignored. The running operation continues unaffected and operands are not relatched.
- Countdown:
  - The counter decrements each edge while busy=1.
  - At the edge where the counter goes 1→0, HI/LO are written with the result and busy drops.
  - Timing: start in cycle t gives busy=1 in cycles t+1..t+N, and the new HI/LO plus busy=0 in cycle t+N+1.
- Result computation:
  - mult: signed 32×32→64; HI=product[63:32], LO=product[31:0].
  - multu: same as mult, unsigned.
  - div: LO=quotient truncated toward zero; HI=remainder carrying the sign of the dividend (signed / and % semantics).
  - divu: same as div, unsigned.
  - Result may be computed at launch or at commit; it is only visible at commit.
- Divide by zero (B=0 on div/divu):
  - The full DIV_CYCLES busy period still occurs.
  - HI and LO retain their prior values.
- Signed overflow case (div 0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0. No exception is raised.
- mthi/mtlo:
  - Take effect at the edge when busy=0; the new value is visible on out the next cycle.
  - Ignored while busy=1 (the hazard unit guarantees they are stalled).
  - hi_we and lo_we together: both HI and LO are written with A.
- start together with hi_we/lo_we in the same cycle (busy=0): start wins and the write is ignored.
- out tracks committed HI/LO only. In-flight results are never visible and no internal bypass exists. While busy=1, out shows the old HI/LO.
- Stall contract (documented for the hazard unit): an MD-class instruction in ID stalls while (busy | start). The unit itself does not gate any inputs beyond the rules above.

Test Plan:
- Reset, then read: hold reset 2 cycles, release; rd_sel=0/1 -> out=0x00000000 both; busy=0.
- Signed mult: A=0xFFFFFFFE (−2), B=0x00000003, md_op=00, start 1 cycle -> busy=1 for exactly 5 cycles; next cycle HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu/divu: A=0xFFFFFFFE, B=3:
  - multu -> HI=0x00000002, LO=0xFFFFFFFA after 5 busy cycles.
  - then divu A=7, B=2 -> after 10 busy cycles LO=3, HI=1.
- Signed div with negative dividend and divide by zero:
  - div A=0xFFFFFFF9 (−7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - then div with B=0 -> busy 10 cycles, HI/LO unchanged.
- Ignored inputs while busy: during a mult, pulse start (div) and hi_we with A=0x12345678 -> mult result commits at the original cycle; no div runs; HI not overwritten. After busy=0, mthi A=0x12345678 -> out(rd_sel=1)=0x12345678 next cycle.
- Reset mid-op: start mult A=5, B=6 with HI/LO preloaded 0xAAAA0000/0x0000BBBB; assert reset at busy cycle 3 -> busy=0, HI=LO=0 next cycle; product 30 never appears.
